// File: rtl/riscv_dp_regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational and can optionally bypass same-cycle writeback data.
module riscv_dp_regfile_mp #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 5,
    parameter int MP_RD_PORTS   = 2,
    parameter int MP_WR_PORTS   = 1,
    parameter int MP_BYPASS     = 1,
    parameter int MP_ZERO_REG   = 1
) (
    input  logic                                   iclk,
    input  logic                                   irst_n,
    input  logic [MP_RD_PORTS*MP_ADDR_WIDTH-1:0]   iaddr_rd,
    output logic [MP_RD_PORTS*MP_DATA_WIDTH-1:0]   ord_data,
    output logic [MP_RD_PORTS-1:0]                 ord_busy,
    input  logic [MP_WR_PORTS-1:0]                 iwr_en,
    input  logic [MP_WR_PORTS*MP_ADDR_WIDTH-1:0]   iaddr_wr,
    input  logic [MP_WR_PORTS*MP_DATA_WIDTH-1:0]   iwr_data,
    input  logic                                   iiss_en,
    input  logic [MP_ADDR_WIDTH-1:0]               iaddr_iss,
    output logic [(2**MP_ADDR_WIDTH)-1:0]          obusy_vec
);

    localparam int LP_REG_NUM = 2 ** MP_ADDR_WIDTH;

    logic [MP_DATA_WIDTH-1:0] regs_q [LP_REG_NUM];
    logic [MP_DATA_WIDTH-1:0] regs_d [LP_REG_NUM];
    logic [LP_REG_NUM-1:0]    busy_q;
    logic [LP_REG_NUM-1:0]    busy_d;

    logic [MP_ADDR_WIDTH-1:0] wr_addr [MP_WR_PORTS];
    logic [MP_DATA_WIDTH-1:0] wr_data [MP_WR_PORTS];
    logic [MP_WR_PORTS-1:0]   wr_live;
    logic [LP_REG_NUM-1:0]    wr_hit;

    // A write is live only if enabled and not aimed at the hardwired zero register.
    always_comb begin
        wr_live = '0;
        for (int w = 0; w < MP_WR_PORTS; w++) begin
            wr_addr[w] = iaddr_wr[w*MP_ADDR_WIDTH +: MP_ADDR_WIDTH];
            wr_data[w] = iwr_data[w*MP_DATA_WIDTH +: MP_DATA_WIDTH];
            wr_live[w] = iwr_en[w] &&
                         !((MP_ZERO_REG != 0) && (wr_addr[w] == '0));
        end
    end

    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int w = 0; w < MP_WR_PORTS; w++) begin
            if (wr_live[w]) begin
                regs_d[wr_addr[w]] = wr_data[w];
                wr_hit[wr_addr[w]] = 1'b1;
            end
        end
    end

    // Issue beats a same-cycle writeback: the newly issued producer owns the register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < LP_REG_NUM; r++) begin
            if (iiss_en && (iaddr_iss == MP_ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        if (MP_ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int r = 0; r < LP_REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [MP_ADDR_WIDTH-1:0] rd_addr [MP_RD_PORTS];
    logic [MP_DATA_WIDTH-1:0] rd_data [MP_RD_PORTS];
    logic [MP_RD_PORTS-1:0]   rd_busy;

    // Later write ports override earlier ones, matching the write priority.
    always_comb begin
        ord_data = '0;
        rd_busy  = '0;
        for (int k = 0; k < MP_RD_PORTS; k++) begin
            rd_addr[k] = iaddr_rd[k*MP_ADDR_WIDTH +: MP_ADDR_WIDTH];
            rd_data[k] = regs_q[rd_addr[k]];
            rd_busy[k] = busy_q[rd_addr[k]];
            if (MP_BYPASS != 0) begin
                for (int w = 0; w < MP_WR_PORTS; w++) begin
                    if (wr_live[w] && (wr_addr[w] == rd_addr[k])) begin
                        rd_data[k] = wr_data[w];
                        rd_busy[k] = 1'b0;
                    end
                end
            end
            if ((MP_ZERO_REG != 0) && (rd_addr[k] == '0)) begin
                rd_data[k] = '0;
                rd_busy[k] = 1'b0;
            end
            ord_data[k*MP_DATA_WIDTH +: MP_DATA_WIDTH] = rd_data[k];
        end
    end

    assign ord_busy  = rd_busy;
    assign obusy_vec = busy_q;

endmodule

// File: tb/tb_riscv_dp_regfile_mp.sv
// Directed bench: two register-file instances (bypass on / bypass off) share stimulus.
module tb_riscv_dp_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  addr_rd;
    logic [1:0]  wr_en;
    logic [9:0]  addr_wr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  addr_iss;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  bsy_b, bsy_n;
    logic [31:0] vec_b, vec_n;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_dp_regfile_mp #(
        .MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(5), .MP_RD_PORTS(2),
        .MP_WR_PORTS(2), .MP_BYPASS(1), .MP_ZERO_REG(1)
    ) dut_byp (
        .iclk(clk), .irst_n(rst_n), .iaddr_rd(addr_rd), .ord_data(rd_b),
        .ord_busy(bsy_b), .iwr_en(wr_en), .iaddr_wr(addr_wr), .iwr_data(wr_data),
        .iiss_en(iss_en), .iaddr_iss(addr_iss), .obusy_vec(vec_b)
    );

    riscv_dp_regfile_mp #(
        .MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(5), .MP_RD_PORTS(2),
        .MP_WR_PORTS(2), .MP_BYPASS(0), .MP_ZERO_REG(1)
    ) dut_nob (
        .iclk(clk), .irst_n(rst_n), .iaddr_rd(addr_rd), .ord_data(rd_n),
        .ord_busy(bsy_n), .iwr_en(wr_en), .iaddr_wr(addr_wr), .iwr_data(wr_data),
        .iiss_en(iss_en), .iaddr_iss(addr_iss), .obusy_vec(vec_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        iss_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]           = 1'b1;
        addr_wr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        addr_rd = {a1, a0};
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en   = 1'b1;
        addr_iss = a;
    endtask

    initial begin
        rst_n = 1'b0;
        addr_rd = '0; wr_en = '0; addr_wr = '0; wr_data = '0;
        iss_en = 1'b0; addr_iss = '0;

        tick();
        tick();
        set_rd(5'd5, 5'd7);
        #1;
        check_eq("rst_data_p0", rd_b[31:0], 32'h0);
        check_eq("rst_vec", vec_b, 32'h0);
        rst_n = 1'b1;

        // async clear mid-cycle
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check_eq("r5_written", rd_b[31:0], 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check_eq("r5_async_clr_byp", rd_b[31:0], 32'h0);
        check_eq("r5_async_clr_nob", rd_n[31:0], 32'h0);
        check_eq("vec_async_clr", vec_b, 32'h0);
        rst_n = 1'b1;

        // write r7, read both ports
        tick();
        set_wr(0, 5'd7, 32'h12345678);
        set_rd(5'd7, 5'd7);
        #1;
        check_eq("r7_nob_same_cycle", rd_n[31:0], 32'h0);
        tick();
        idle();
        #1;
        check_eq("r7_byp_p0", rd_b[31:0], 32'h12345678);
        check_eq("r7_byp_p1", rd_b[63:32], 32'h12345678);
        check_eq("r7_nob_p1", rd_n[63:32], 32'h12345678);

        // r0 hardwired
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd7);
        #1;
        check_eq("r0_no_bypass", rd_b[31:0], 32'h0);
        tick();
        idle();
        #1;
        check_eq("r0_reads_zero", rd_b[31:0], 32'h0);
        check_eq("r0_reads_zero_nob", rd_n[31:0], 32'h0);

        // bypass vs stored value
        set_wr(0, 5'd3, 32'h11111111);
        tick();
        idle();
        set_wr(0, 5'd3, 32'hA5A5A5A5);
        set_rd(5'd3, 5'd7);
        #1;
        check_eq("r3_bypass", rd_b[31:0], 32'hA5A5A5A5);
        check_eq("r3_nob_old", rd_n[31:0], 32'h11111111);
        tick();
        idle();
        #1;
        check_eq("r3_nob_new", rd_n[31:0], 32'hA5A5A5A5);

        // write collision, higher port wins
        set_wr(0, 5'd9, 32'h1);
        set_wr(1, 5'd9, 32'h2);
        set_rd(5'd7, 5'd9);
        #1;
        check_eq("r9_collide_bypass", rd_b[63:32], 32'h2);
        tick();
        idle();
        #1;
        check_eq("r9_collide_byp", rd_b[63:32], 32'h2);
        check_eq("r9_collide_nob", rd_n[63:32], 32'h2);

        // scoreboard set / clear
        issue(5'd4);
        set_rd(5'd4, 5'd7);
        tick();
        idle();
        #1;
        check_eq("r4_busy_vec", vec_b, 32'h0000_0010);
        check_eq("r4_ord_busy", {31'b0, bsy_b[0]}, 32'h1);
        tick();
        set_wr(0, 5'd4, 32'h44);
        tick();
        idle();
        #1;
        check_eq("r4_cleared", vec_b, 32'h0);
        check_eq("r4_cleared_nob", vec_n, 32'h0);

        // issue and write same cycle: stays busy
        issue(5'd4);
        set_wr(0, 5'd4, 32'h45);
        tick();
        idle();
        #1;
        check_eq("r4_iss_wr_same", vec_b, 32'h0000_0010);
        issue(5'd4);
        tick();
        idle();
        #1;
        check_eq("r4_reissue", vec_n, 32'h0000_0010);
        set_wr(1, 5'd4, 32'h46);
        tick();
        idle();
        #1;
        check_eq("r4_cleared_p1", vec_b, 32'h0);

        // issue r0 ignored
        issue(5'd0);
        tick();
        idle();
        #1;
        check_eq("r0_never_busy", vec_b, 32'h0);

        // busy bypass on r6
        set_wr(0, 5'd6, 32'h66);
        tick();
        idle();
        issue(5'd6);
        tick();
        idle();
        set_wr(0, 5'd6, 32'h77);
        set_rd(5'd7, 5'd6);
        #1;
        check_eq("r6_byp_busy", {31'b0, bsy_b[1]}, 32'h0);
        check_eq("r6_byp_data", rd_b[63:32], 32'h77);
        check_eq("r6_nob_busy", {31'b0, bsy_n[1]}, 32'h1);
        check_eq("r6_nob_data", rd_n[63:32], 32'h66);
        check_eq("r6_vec_registered", vec_b, 32'h0000_0040);
        tick();
        idle();
        #1;
        check_eq("r6_vec_after", vec_n, 32'h0);
        check_eq("r6_data_after", rd_n[63:32], 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
